// File: rtl/disparity_axis_tx.sv
// Output stage of the disparity pipeline: frames the {sof,disp} pixel stream as
// AXI4-Stream video (tuser=SOF, tlast=EOL) through a small first-word-fall-through FIFO.
module disparity_axis_tx #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          pixelEN,
  input  logic [8:0]                    disparity,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          sync_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    STREAM   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q, overflow_d;
  logic            sync_err_q, sync_err_d;

  logic [9:0]      fifo_mem_q [FIFO_DEPTH];

  logic            accept;
  logic            sof_in;
  logic            in_frame;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   cur_row;
  logic            last_col;
  logic            last_row;
  logic            wr_req;
  logic            wr_en;
  logic            rd_en;
  logic            fifo_full;
  logic            fifo_empty;
  logic [9:0]      wr_entry;
  logic [9:0]      head;

  always_comb begin
    accept     = en && pixelEN;
    sof_in     = disparity[8];
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_FULL);
    rd_en      = !fifo_empty && m_axis_tready;

    // A sof beat always counts as pixel (0,0), whether it opens or restarts a frame.
    in_frame = (state_q == STREAM) || sof_in;
    cur_col  = sof_in ? '0 : col_q;
    cur_row  = sof_in ? '0 : row_q;
    last_col = (cur_col == COL_LAST);
    last_row = (cur_row == ROW_LAST);
    wr_entry = {sof_in, last_col, disparity[7:0]};

    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    sync_err_d   = sync_err_q;
    wr_req       = 1'b0;

    if (accept && in_frame) begin
      wr_req  = 1'b1;
      state_d = STREAM;
      if ((state_q == STREAM) && sof_in && ((col_q != '0) || (row_q != '0))) begin
        sync_err_d = 1'b1;
      end
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d        = '0;
          state_d      = WAIT_SOF;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_row + RW'(1);
        end
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end

    // A beat arriving on a full FIFO may still land if the head leaves this cycle.
    wr_en = wr_req && (!fifo_full || rd_en);
    if (wr_req && !wr_en) begin
      overflow_d = 1'b1;
    end

    wr_ptr_d = wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      row_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head          = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    m_axis_tvalid = !fifo_empty;
    m_axis_tuser  = head[9];
    m_axis_tlast  = head[8];
    m_axis_tdata  = head[7:0];
    frame_done    = frame_done_q;
    overflow      = overflow_q;
    sync_err      = sync_err_q;
    fifo_level    = level_q;
  end

endmodule

// File: tb/tb_disparity_axis_tx.sv
// Directed bench for disparity_axis_tx with a 4x2 frame and a 4-entry FIFO.
module tb_disparity_axis_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pixelEN;
  logic [8:0] disparity;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tuser;
  logic       m_axis_tlast;
  logic       frame_done;
  logic       overflow;
  logic       sync_err;
  logic [2:0] fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  disparity_axis_tx #(
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pixelEN      (pixelEN),
    .disparity    (disparity),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .sync_err     (sync_err),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       pix;
    logic [8:0] din;
    logic       rdy;
    logic       vld;
    logic [7:0] data;
    logic       user;
    logic       last;
    logic [2:0] lvl;
    logic       fd;
    logic       ovf;
    logic       serr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [7:0] data,
                           input logic user, input logic last, input logic [2:0] lvl,
                           input logic fd, input logic ovf, input logic serr);
    chk({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'(vld));
    chk({tag, ".tdata"},  32'(m_axis_tdata),  32'(data));
    chk({tag, ".tuser"},  32'(m_axis_tuser),  32'(user));
    chk({tag, ".tlast"},  32'(m_axis_tlast),  32'(last));
    chk({tag, ".level"},  32'(fifo_level),    32'(lvl));
    chk({tag, ".fdone"},  32'(frame_done),    32'(fd));
    chk({tag, ".ovf"},    32'(overflow),      32'(ovf));
    chk({tag, ".serr"},   32'(sync_err),      32'(serr));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [8:0] d);
    en        = 1'b1;
    pixelEN   = 1'b1;
    disparity = d;
    cyc();
  endtask

  task automatic idle();
    en        = 1'b0;
    pixelEN   = 1'b0;
    disparity = 9'h000;
  endtask

  task automatic do_reset();
    idle();
    m_axis_tready = 1'b1;
    rst_n = 1'b0;
    cyc();
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic add(input logic e, input logic p, input logic [8:0] d, input logic r,
                     input logic v, input logic [7:0] dat, input logic u, input logic l,
                     input logic [2:0] lv, input logic fd);
    vecs.push_back('{e, p, d, r, v, dat, u, l, lv, fd, 1'b0, 1'b0});
  endtask

  // Complete 4x2 frame with tready high: each beat appears at the head the next cycle.
  task automatic add_frame();
    for (int k = 0; k < 8; k++) begin
      add(1'b1, 1'b1, (k == 0) ? 9'h100 : 9'(k), 1'b1,
          1'b1, 8'(k), k == 0, (k == 3) || (k == 7), 3'd1, k == 7);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    m_axis_tready = 1'b1;

    add_frame();
    add(1'b1, 1'b0, 9'h1FF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 1'b1, 9'h066, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 9'h100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    add_frame();
    add(1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    cyc();
    check_out("async_reset", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      en            = vecs[i].en;
      pixelEN       = vecs[i].pix;
      disparity     = vecs[i].din;
      m_axis_tready = vecs[i].rdy;
      cyc();
      check_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].data, vecs[i].user,
                vecs[i].last, vecs[i].lvl, vecs[i].fd, vecs[i].ovf, vecs[i].serr);
    end

    // Backpressure: six beats into a four-entry FIFO, then drain.
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat((i == 0) ? 9'h100 : 9'(i));
      check_out($sformatf("stall%0d", i), 1'b1, 8'h00, 1'b1, 1'b0,
                (i < 3) ? 3'(i + 1) : 3'd4, 1'b0, i >= 4, 1'b0);
    end
    idle();
    m_axis_tready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc();
      check_out($sformatf("drain%0d", i), 1'b1, 8'(i), 1'b0, i == 3, 3'(4 - i),
                1'b0, 1'b1, 1'b0);
    end
    cyc();
    check_out("drain_empty", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Full FIFO with a read and a write every cycle.
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) beat((i == 0) ? 9'h100 : 9'(i));
    check_out("fill", 1'b1, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      beat(9'(i));
      check_out($sformatf("steady%0d", i), 1'b1, 8'(i - 3), 1'b0, (i - 3) == 3, 3'd4,
                i == 7, 1'b0, 1'b0);
    end
    idle();
    for (int i = 5; i < 8; i++) begin
      cyc();
      check_out($sformatf("sdrain%0d", i), 1'b1, 8'(i), 1'b0, i == 7, 3'(8 - i),
                1'b0, 1'b0, 1'b0);
    end
    cyc();
    check_out("sdrain_empty", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Resync: sof arrives at col=2,row=1 of a running frame.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      beat((i == 0) ? 9'h100 : 9'(i));
      check_out($sformatf("pre%0d", i), 1'b1, 8'(i), i == 0, i == 3, 3'd1, 1'b0,
                1'b0, 1'b0);
    end
    beat(9'h1AA);
    check_out("resync", 1'b1, 8'hAA, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++) begin
      beat(9'(k));
      check_out($sformatf("post%0d", k), 1'b1, 8'(k), 1'b0, (k == 3) || (k == 7), 3'd1,
                k == 7, 1'b0, 1'b1);
    end
    idle();
    cyc();
    check_out("post_idle", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame with three entries queued and sync_err raised.
    do_reset();
    m_axis_tready = 1'b0;
    beat(9'h100);
    beat(9'h001);
    beat(9'h102);
    idle();
    check_out("pre_rst", 1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      beat((k == 0) ? 9'h100 : 9'(k));
      check_out($sformatf("clean%0d", k), 1'b1, 8'(k), k == 0, (k == 3) || (k == 7),
                3'd1, k == 7, 1'b0, 1'b0);
    end
    idle();
    cyc();
    check_out("clean_idle", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
